// File: rtl/key_pkg.sv
// key_pkg: shared constants and FSM state type for key_word_writer; KEY_WRITER_PARITY_EN adds the PARITY state
package key_pkg;
    localparam int NUM_KEY_WORDS = 3;
    localparam int DEFAULT_WORD_W = 8;
`ifdef KEY_WRITER_PARITY_EN
    typedef enum logic [1:0] {IDLE, SEND, PARITY, DONE} state_t;
`else
    typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;
`endif
endpackage

// File: rtl/key_word_writer.sv
// key_word_writer: writes a captured 3-word key into a FIFO, least-significant word first
// KEY_WRITER_PARITY_EN appends one XOR parity word after the key words
module key_word_writer
    import key_pkg::*;
#(
    parameter int WORD_W = DEFAULT_WORD_W
) (
    input  logic                            clk,
    input  logic                            n_rst,
    input  logic                            key_valid,
    input  logic [NUM_KEY_WORDS*WORD_W-1:0] key_data,
    output logic                            key_ready,
    input  logic                            fifo_full,
    output logic                            fifo_wr,
    output logic [WORD_W-1:0]               fifo_wdata,
    input  logic                            flush,
    output logic                            busy,
    output logic [1:0]                      word_idx,
    output logic                            done
);
    state_t state, state_nx;
    logic [NUM_KEY_WORDS*WORD_W-1:0] key_q;
    logic [WORD_W-1:0] words [NUM_KEY_WORDS];
    logic capture, last_word;

    always_comb begin
        for (int k = 0; k < NUM_KEY_WORDS; k++) words[k] = key_q[k*WORD_W +: WORD_W];
    end

    assign capture   = state == IDLE && key_valid && !flush;
    assign last_word = word_idx == 2'(NUM_KEY_WORDS - 1);
    assign key_ready = state == IDLE;
    assign busy      = state != IDLE;
    assign done      = state == DONE && !flush;

`ifdef KEY_WRITER_PARITY_EN
    logic [WORD_W-1:0] parity;
    always_comb begin
        parity = '0;
        for (int k = 0; k < NUM_KEY_WORDS; k++) parity = parity ^ words[k];
    end
    assign fifo_wr    = (state == SEND || state == PARITY) && !fifo_full && !flush;
    assign fifo_wdata = state == PARITY ? parity : words[word_idx];
    localparam state_t AFTER_SEND = PARITY;
`else
    assign fifo_wr    = state == SEND && !fifo_full && !flush;
    assign fifo_wdata = words[word_idx];
    localparam state_t AFTER_SEND = DONE;
`endif

    always_comb begin
        state_nx = IDLE;
        case (state)
            IDLE:    state_nx = capture ? SEND : IDLE;
            SEND:    state_nx = fifo_wr && last_word ? AFTER_SEND : SEND;
`ifdef KEY_WRITER_PARITY_EN
            PARITY:  state_nx = fifo_wr ? DONE : PARITY;
`endif
            default: state_nx = IDLE;
        endcase
        if (flush) state_nx = IDLE;
    end

    // word_idx wraps to 0 on the last key word, so it is already 0 in PARITY/DONE
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state    <= IDLE;
            key_q    <= '0;
            word_idx <= '0;
        end else begin
            state <= state_nx;
            if (capture) key_q <= key_data;
            if (flush || capture || state == DONE) word_idx <= '0;
            else if (state == SEND && fifo_wr) word_idx <= last_word ? 2'd0 : word_idx + 2'd1;
        end
    end
endmodule

// File: tb/tb_key_word_writer.sv
// tb_key_word_writer: directed self-checking bench for key_word_writer (WORD_W=8)
module tb_key_word_writer;
    logic clk = 0, n_rst = 0, key_valid = 0, fifo_full = 0, flush = 0;
    logic [23:0] key_data = '0;
    logic key_ready, fifo_wr, busy, done;
    logic [7:0] fifo_wdata;
    logic [1:0] word_idx;
    int passed = 0, total = 0;

    key_word_writer #(.WORD_W(8)) dut (
        .clk(clk), .n_rst(n_rst), .key_valid(key_valid), .key_data(key_data),
        .key_ready(key_ready), .fifo_full(fifo_full), .fifo_wr(fifo_wr),
        .fifo_wdata(fifo_wdata), .flush(flush), .busy(busy),
        .word_idx(word_idx), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // one cycle: drive inputs just after the edge, then let combinational outputs settle
    task automatic cyc(input logic kv, input logic [23:0] kd, input logic ff, input logic fl);
        @(posedge clk);
        #1;
        key_valid = kv;
        key_data  = kd;
        fifo_full = ff;
        flush     = fl;
        #1;
    endtask

    task automatic chk_wr(input string tag, input logic [7:0] w, input logic [1:0] idx);
        chk({tag, " wr"}, fifo_wr, 1);
        chk({tag, " wdata"}, fifo_wdata, w);
        chk({tag, " idx"}, word_idx, idx);
    endtask

    task automatic tail(input string tag, input logic [7:0] par);
`ifdef KEY_WRITER_PARITY_EN
        cyc(0, '0, 0, 0);
        chk_wr({tag, " parity"}, par, 0);
`else
        chk({tag, " parity unused"}, {24'd0, par}, {24'd0, par});
`endif
        cyc(0, '0, 0, 0);
        chk({tag, " done"}, done, 1);
        chk({tag, " done wr"}, fifo_wr, 0);
        chk({tag, " done idx"}, word_idx, 0);
        chk({tag, " done busy"}, busy, 1);
        cyc(0, '0, 0, 0);
        chk({tag, " idle ready"}, key_ready, 1);
        chk({tag, " idle done"}, done, 0);
        chk({tag, " idle busy"}, busy, 0);
    endtask

    initial begin
        #2;
        chk("rst ready", key_ready, 1);
        chk("rst busy", busy, 0);
        chk("rst wr", fifo_wr, 0);
        chk("rst done", done, 0);
        chk("rst idx", word_idx, 0);
        chk("rst wdata", fifo_wdata, 8'h00);
        @(negedge clk);
        n_rst = 1;

        // plain send, no stalls
        cyc(1, 24'hC3B2A1, 0, 0);
        chk("t1 c0 ready", key_ready, 1);
        chk("t1 c0 wr", fifo_wr, 0);
        cyc(0, '0, 0, 0);
        chk_wr("t1 c1", 8'hA1, 0);
        chk("t1 c1 ready", key_ready, 0);
        cyc(0, '0, 0, 0);
        chk_wr("t1 c2", 8'hB2, 1);
        cyc(0, '0, 0, 0);
        chk_wr("t1 c3", 8'hC3, 2);
        tail("t1", 8'hD0);

        // fifo_full during cycles 2-3
        cyc(1, 24'hC3B2A1, 0, 0);
        cyc(0, '0, 0, 0);
        chk_wr("t2 c1", 8'hA1, 0);
        for (int i = 0; i < 2; i++) begin
            cyc(0, '0, 1, 0);
            chk("t2 stall wr", fifo_wr, 0);
            chk("t2 stall wdata", fifo_wdata, 8'hB2);
            chk("t2 stall idx", word_idx, 1);
        end
        cyc(0, '0, 0, 0);
        chk_wr("t2 c4", 8'hB2, 1);
        cyc(0, '0, 0, 0);
        chk_wr("t2 c5", 8'hC3, 2);
        tail("t2", 8'hD0);

        // flush in cycle 2, new key accepted at cycle 3
        cyc(1, 24'hC3B2A1, 0, 0);
        cyc(0, '0, 0, 0);
        chk_wr("t3 c1", 8'hA1, 0);
        cyc(0, '0, 0, 1);
        chk("t3 flush wr", fifo_wr, 0);
        chk("t3 flush done", done, 0);
        cyc(1, 24'h112233, 0, 0);
        chk("t3 c3 ready", key_ready, 1);
        chk("t3 c3 busy", busy, 0);
        chk("t3 c3 idx", word_idx, 0);
        chk("t3 c3 done", done, 0);
        cyc(0, '0, 0, 0);
        chk_wr("t3 c4", 8'h33, 0);
        cyc(0, '0, 0, 0);
        chk_wr("t3 c5", 8'h22, 1);
        cyc(0, '0, 0, 0);
        chk_wr("t3 c6", 8'h11, 2);
        tail("t3", 8'h00);

        // asynchronous reset in cycle 2
        cyc(1, 24'hC3B2A1, 0, 0);
        cyc(0, '0, 0, 0);
        chk_wr("t4 c1", 8'hA1, 0);
        cyc(0, '0, 0, 0);
        n_rst = 0;
        #1;
        chk("t4 rst wr", fifo_wr, 0);
        chk("t4 rst done", done, 0);
        chk("t4 rst busy", busy, 0);
        chk("t4 rst ready", key_ready, 1);
        chk("t4 rst idx", word_idx, 0);
        chk("t4 rst wdata", fifo_wdata, 8'h00);
        @(negedge clk);
        n_rst = 1;
        for (int i = 0; i < 3; i++) begin
            cyc(0, '0, 0, 0);
            chk("t4 post wr", fifo_wr, 0);
            chk("t4 post ready", key_ready, 1);
            chk("t4 post busy", busy, 0);
        end

        // key_valid during a send is ignored
        cyc(1, 24'hC3B2A1, 0, 0);
        cyc(1, 24'h112233, 0, 0);
        chk_wr("t5 c1", 8'hA1, 0);
        chk("t5 c1 ready", key_ready, 0);
        cyc(0, '0, 0, 0);
        chk_wr("t5 c2", 8'hB2, 1);
        cyc(0, '0, 0, 0);
        chk_wr("t5 c3", 8'hC3, 2);
        tail("t5", 8'hD0);
        chk("t5 held word0", fifo_wdata, 8'hA1);

        // flush together with key_valid in IDLE blocks capture
        cyc(1, 24'h445566, 0, 1);
        cyc(0, '0, 0, 0);
        chk("t6 busy", busy, 0);
        chk("t6 ready", key_ready, 1);
        chk("t6 wr", fifo_wr, 0);
        chk("t6 wdata", fifo_wdata, 8'hA1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
